// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

    // Read-mode selectors for p_FWFT.
    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Width of an occupancy counter that must hold 0..capacity inclusive.
    function automatic int unsigned fifo_cnt_width(input int unsigned capacity);
        return $clog2(capacity + 1);
    endfunction

    // Width of a pointer addressing 0..capacity-1 (never less than one bit).
    function automatic int unsigned fifo_ptr_width(input int unsigned capacity);
        return (capacity < 2) ? 1 : $clog2(capacity);
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Storage array for fifo_sync: one synchronous write port, one combinational
// read port, no reset on the array contents.
//   clk        : clock
//   wr_en      : write strobe
//   wr_addr    : write address
//   wr_data    : write word
//   rd_addr    : read address
//   rd_data_c  : word at rd_addr (combinational)
module fifo_sync_mem
    import fifo_pkg::*;
#(
    parameter int unsigned p_WIDTH    = 8,
    parameter int unsigned p_CAPACITY = 16,
    localparam int unsigned AW        = fifo_ptr_width(p_CAPACITY)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [p_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [p_WIDTH-1:0] rd_data_c
);

    logic [p_WIDTH-1:0] mem_q [p_CAPACITY];

    // Write port; the array is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read; the parent registers the result as needed.
    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy flags, sticky error flags and a choice of
// registered-read or first-word-fall-through output.
//   clk, rst                  : clock, synchronous active-high reset
//   wrena, wrdata             : write request and word
//   rdena                     : read request (mode 0) / pop (mode 1)
//   rddata, rdvalid           : read word and its valid flag
//   full, empty, afull, aempty: occupancy flags
//   count                     : current occupancy
//   overflow, underflow       : sticky error flags, cleared only by rst
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned p_WIDTH    = 8,
    parameter int unsigned p_CAPACITY = 16,
    parameter int unsigned p_AFULL    = p_CAPACITY - 2,
    parameter int unsigned p_AEMPTY   = 2,
    parameter int unsigned p_FWFT     = FWFT_OFF,
    localparam int unsigned CW        = fifo_cnt_width(p_CAPACITY)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrena,
    input  logic [p_WIDTH-1:0] wrdata,
    input  logic               rdena,
    output logic [p_WIDTH-1:0] rddata,
    output logic               rdvalid,
    output logic               full,
    output logic               empty,
    output logic               afull,
    output logic               aempty,
    output logic [CW-1:0]      count,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned   PW       = fifo_ptr_width(p_CAPACITY);
    localparam logic [PW-1:0] PTR_LAST = PW'(p_CAPACITY - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(p_CAPACITY);

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               afull_q, afull_d;
    logic               aempty_q, aempty_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               rdvalid_q, rdvalid_d;
    logic [p_WIDTH-1:0] rddata_q, rddata_d;

    logic               wr_acc_c;
    logic               rd_acc_c;
    logic               bypass_c;
    logic [PW-1:0]      mem_raddr_c;
    logic [p_WIDTH-1:0] mem_rdata_c;

    // Pointer advance with wrap at a non-power-of-two capacity.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    endfunction

    fifo_sync_mem #(
        .p_WIDTH    (p_WIDTH),
        .p_CAPACITY (p_CAPACITY)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_acc_c & ~rst),
        .wr_addr   (wr_ptr_q),
        .wr_data   (wrdata),
        .rd_addr   (mem_raddr_c),
        .rd_data_c (mem_rdata_c)
    );

    // Acceptance, pointers, occupancy, flags and read-side next state.
    always_comb begin
        wr_acc_c    = wrena & ~full_q;
        rd_acc_c    = rdena & ~empty_q;
        wr_ptr_d    = wr_acc_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = rd_acc_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q;
        bypass_c    = 1'b0;
        mem_raddr_c = rd_ptr_q;
        rdvalid_d   = 1'b0;
        rddata_d    = rddata_q;

        if (wr_acc_c && !rd_acc_c) begin
            count_d = count_q + CW'(1);
        end else if (!wr_acc_c && rd_acc_c) begin
            count_d = count_q - CW'(1);
        end

        full_d      = (count_d == CNT_MAX);
        empty_d     = (count_d == '0);
        afull_d     = (32'(count_d) >= 32'(p_AFULL));
        aempty_d    = (32'(count_d) <= 32'(p_AEMPTY));
        overflow_d  = overflow_q | (wrena & full_q);
        underflow_d = underflow_q | (rdena & empty_q);

        if (p_FWFT == FWFT_ON) begin
            // Present the post-edge head; the word being written becomes the
            // head when nothing older survives this edge, and it is not in
            // the array yet, so forward it directly.
            mem_raddr_c = rd_ptr_d;
            bypass_c    = wr_acc_c &&
                          ((count_q == '0) || ((count_q == CW'(1)) && rd_acc_c));
            rdvalid_d   = ~empty_d;
            if (empty_d) begin
                rddata_d = '0;
            end else if (bypass_c) begin
                rddata_d = wrdata;
            end else begin
                rddata_d = mem_rdata_c;
            end
        end else begin
            // Registered read: load the head on an accepted read, else hold.
            rdvalid_d = rd_acc_c;
            if (rd_acc_c) begin
                rddata_d = mem_rdata_c;
            end
        end
    end

    // State registers with synchronous reset taking priority over requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= (p_AFULL == 0);
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rdvalid_q   <= 1'b0;
            rddata_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rdvalid_q   <= rdvalid_d;
            rddata_q    <= rddata_d;
        end
    end

    assign rddata    = rddata_q;
    assign rdvalid   = rdvalid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign afull     = afull_q;
    assign aempty    = aempty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: a registered-read and a fall-through instance share the
// same stimulus and are compared against a queue-based model.
module tb_fifo_sync;

    localparam int unsigned W   = 3;
    localparam int unsigned CAP = 7;
    localparam int unsigned AF  = CAP - 2;
    localparam int unsigned AE  = 2;
    localparam int unsigned CW  = $clog2(CAP + 1);

    logic          clk;
    logic          rst;
    logic          wrena;
    logic          rdena;
    logic [W-1:0]  wrdata;

    logic [W-1:0]  rddata0, rddata1;
    logic          rdvalid0, rdvalid1;
    logic          full0, full1, empty0, empty1;
    logic          afull0, afull1, aempty0, aempty1;
    logic [CW-1:0] count0, count1;
    logic          overflow0, overflow1, underflow0, underflow1;

    int checks;
    int failures;

    // Reference model: contents as a queue plus the observable side state.
    logic [W-1:0] mq[$];
    logic         m_ov;
    logic         m_un;
    logic         m_rv0;
    logic [W-1:0] m_rd0;
    logic         m_was_rst;

    fifo_sync #(
        .p_WIDTH(W), .p_CAPACITY(CAP), .p_AFULL(AF), .p_AEMPTY(AE), .p_FWFT(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .wrena(wrena), .wrdata(wrdata), .rdena(rdena),
        .rddata(rddata0), .rdvalid(rdvalid0), .full(full0), .empty(empty0),
        .afull(afull0), .aempty(aempty0), .count(count0),
        .overflow(overflow0), .underflow(underflow0)
    );

    fifo_sync #(
        .p_WIDTH(W), .p_CAPACITY(CAP), .p_AFULL(AF), .p_AEMPTY(AE), .p_FWFT(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .wrena(wrena), .wrdata(wrdata), .rdena(rdena),
        .rddata(rddata1), .rdvalid(rdvalid1), .full(full1), .empty(empty1),
        .afull(afull1), .aempty(aempty1), .count(count1),
        .overflow(overflow1), .underflow(underflow1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using pre-edge occupancy.
    task automatic model_edge(input logic r, input logic w, input logic [W-1:0] d, input logic rd);
        bit was_full;
        bit was_empty;
        m_was_rst = r;
        if (r) begin
            mq.delete();
            m_ov  = 1'b0;
            m_un  = 1'b0;
            m_rv0 = 1'b0;
            m_rd0 = '0;
        end else begin
            was_full  = (mq.size() == CAP);
            was_empty = (mq.size() == 0);
            if (w && was_full) m_ov = 1'b1;
            if (rd && was_empty) m_un = 1'b1;
            if (rd && !was_empty) begin
                m_rd0 = mq.pop_front();
                m_rv0 = 1'b1;
            end else begin
                m_rv0 = 1'b0;
            end
            if (w && !was_full) mq.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check_eq("m0_count",     32'(count0),     32'(n));
        check_eq("m0_full",      32'(full0),      32'(n == CAP));
        check_eq("m0_empty",     32'(empty0),     32'(n == 0));
        check_eq("m0_afull",     32'(afull0),     32'(n >= AF));
        check_eq("m0_aempty",    32'(aempty0),    32'(n <= AE));
        check_eq("m0_overflow",  32'(overflow0),  32'(m_ov));
        check_eq("m0_underflow", 32'(underflow0), 32'(m_un));
        check_eq("m0_rdvalid",   32'(rdvalid0),   32'(m_rv0));
        check_eq("m0_rddata",    32'(rddata0),    32'(m_rd0));
        check_eq("m1_count",     32'(count1),     32'(n));
        check_eq("m1_overflow",  32'(overflow1),  32'(m_ov));
        check_eq("m1_underflow", 32'(underflow1), 32'(m_un));
        check_eq("m1_rdvalid",   32'(rdvalid1),   32'(n != 0));
        if (n != 0) begin
            check_eq("m1_rddata", 32'(rddata1), 32'(mq[0]));
        end else if (m_was_rst) begin
            check_eq("m1_rddata_rst", 32'(rddata1), 32'd0);
        end
    endtask

    // One clock: drive on the falling edge, model at the rising edge, check after it.
    task automatic step(input logic r, input logic w, input logic [W-1:0] d, input logic rd);
        @(negedge clk);
        rst    = r;
        wrena  = w;
        wrdata = d;
        rdena  = rd;
        @(posedge clk);
        model_edge(r, w, d, rd);
        #1;
        check_all();
    endtask

    initial begin
        logic [W-1:0] v;
        int pw;
        int pr;
        clk    = 1'b0;
        rst    = 1'b1;
        wrena  = 1'b0;
        rdena  = 1'b0;
        wrdata = '0;
        checks   = 0;
        failures = 0;
        mq.delete();
        m_ov = 1'b0; m_un = 1'b0; m_rv0 = 1'b0; m_rd0 = '0; m_was_rst = 1'b0;

        // Reset state.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        check_eq("rst_afull", 32'(afull0), 32'(AF == 0));

        // Fill with 7,2,5,0,3,6,1 then drain in order.
        for (int i = 0; i < CAP; i++) step(1'b0, 1'b1, W'((7 + 3 * i) % 8), 1'b0);
        check_eq("fill_count", 32'(count0), 32'd7);
        check_eq("fill_full",  32'(full0),  32'd1);
        for (int i = 0; i < CAP; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            check_eq("drain_data", 32'(rddata0), 32'((7 + 3 * i) % 8));
        end
        check_eq("drain_empty", 32'(empty0), 32'd1);

        // Read from empty sets underflow without disturbing count.
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("uf_flag", 32'(underflow0), 32'd1);

        // Full FIFO with simultaneous write and read: write rejected.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < CAP; i++) step(1'b0, 1'b1, W'(i), 1'b0);
        step(1'b0, 1'b1, 3'd7, 1'b1);
        check_eq("ov_count", 32'(count0), 32'd6);
        check_eq("ov_flag",  32'(overflow0), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        check_eq("ov_sticky", 32'(overflow0), 32'd1);

        // Fall-through: a word written into an empty FIFO appears next cycle.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 3'd5, 1'b0);
        check_eq("fwft_data",  32'(rddata1),  32'd5);
        check_eq("fwft_valid", 32'(rdvalid1), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("fwft_pop_empty", 32'(empty1), 32'd1);

        // Steady state at count 3 with 20 simultaneous write/read cycles.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, W'($urandom), 1'b1);
        check_eq("steady_count", 32'(count0), 32'd3);

        // Reset with a write pending at count 4.
        step(1'b0, 1'b1, W'($urandom), 1'b0);
        step(1'b1, 1'b1, 3'd6, 1'b0);
        check_eq("rstw_count", 32'(count0), 32'd0);
        check_eq("rstw_empty", 32'(empty0), 32'd1);

        // Randomized traffic with drifting write/read bias and rare resets.
        for (int ph = 0; ph < 8; ph++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 99) < pw),
                     W'($urandom),
                     ($urandom_range(0, 99) < pr));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter p_WIDTH, default 8: data word width in bits, at least 1.
REQ-002 SHALL have parameter p_CAPACITY, default 16: storage depth in words, at least 2, not required to be a power of two.
REQ-003 SHALL have parameter p_AFULL, default p_CAPACITY-2: almost-full threshold, in words.
REQ-004 SHALL have parameter p_AEMPTY, default 2: almost-empty threshold, in words.
REQ-005 SHALL have parameter p_FWFT, default 0: read mode; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic samples on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-008 SHALL have port wrena, input, 1 bit: write request.
REQ-009 SHALL have port wrdata, input, p_WIDTH bits: write word.
REQ-010 SHALL have port rdena, input, 1 bit: read request in mode 0, pop in mode 1.
REQ-011 SHALL have port rddata, output, p_WIDTH bits: read word.
REQ-012 SHALL have port rdvalid, output, 1 bit: rddata holds a valid word.
REQ-013 SHALL have ports full, empty, afull and aempty, outputs, 1 bit each: occupancy flags.
REQ-014 SHALL have port count, output, CW bits, where CW = clog2(p_CAPACITY+1): current occupancy.
REQ-015 SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.

Function
REQ-016 SHALL accept a write exactly when wrena=1 and full=0; an accepted write stores wrdata at the write pointer.
REQ-017 SHALL accept a read exactly when rdena=1 and empty=0.
REQ-018 SHALL, on a simultaneous write and read, evaluate acceptance against the pre-edge flags and leave count unchanged when both are accepted.
- Consequence: when full, the write is rejected even if a read is accepted in the same cycle.
REQ-019 SHALL advance each pointer by 1 per accepted operation and wrap it from p_CAPACITY-1 to 0.
REQ-020 SHALL keep count registered and in the range 0..p_CAPACITY.
- full = (count == p_CAPACITY); empty = (count == 0).
- afull = (count >= p_AFULL); aempty = (count <= p_AEMPTY).
- All flags SHALL be valid in the cycle after the causing edge.
REQ-021 SHALL behave as follows in mode 0 (p_FWFT=0):
- an accepted read SHALL load rddata with the head word on the same edge;
- rdvalid SHALL be 1 for exactly the following cycle;
- latency from rdena to data is one clock;
- rddata SHALL hold its value when no read is accepted.
REQ-022 SHALL behave as follows in mode 1 (p_FWFT=1):
- rddata SHALL present the head word and rdvalid SHALL equal ~empty;
- an accepted read pops the head, and the next word appears in the cycle after the edge;
- a word written into an empty FIFO SHALL appear on rddata with rdvalid=1 one cycle after its write edge.
REQ-023 SHALL set overflow on a cycle with wrena=1 and full=1, and hold it until rst.
REQ-024 SHALL set underflow on a cycle with rdena=1 and empty=1, and hold it until rst.
REQ-025 SHALL leave storage, pointers and count unchanged by rejected operations.
REQ-026 SHALL preserve data order exactly, with no loss or duplication, across any number of pointer wraps.

Reset
REQ-027 SHALL, on any rising edge with rst=1, clear pointers, count, overflow, underflow, rdvalid and rddata to 0.
- After that edge: empty=1, aempty=1, full=0, afull=(p_AFULL==0).
REQ-028 SHALL give rst priority over wrena and rdena in the same cycle, with both requests ignored.
REQ-029 SHALL, on rst asserted mid-operation, discard all stored words; the storage array itself need not be cleared.

Structure
REQ-030 SHALL place the count-width function and the mode constants (FWFT_OFF=0, FWFT_ON=1) in a shared package, fifo_pkg, reused by sibling FIFO blocks.
REQ-031 SHALL implement the storage array as the sub-module fifo_sync_mem: one write port and one read port, p_CAPACITY entries of p_WIDTH bits, with no reset on the array.
REQ-032 SHALL implement the pointers, count, flags and read-mode logic in fifo_sync itself.

Verification
REQ-033 SHALL be verified with p_WIDTH=3, p_CAPACITY=7, mode 0, starting at 7 and stepping by 3 mod 8: write 7 words with no reads -> full=1, count=7, afull=1; then 7 reads -> 7,2,5,0,3,6,1 in order with rdvalid=1 each cycle after rdena, and empty=1 at the end.
REQ-034 SHALL be verified with a full FIFO, wrena=1 and rdena=1 in the same cycle -> write rejected, count=6, overflow=1 and held until rst.
REQ-035 SHALL be verified from empty with rdena=1 -> underflow=1, count=0, rdvalid=0.
REQ-036 SHALL be verified in mode 1, capacity 7, by writing 0x5 into an empty FIFO -> rddata=5 and rdvalid=1 one cycle later without rdena, and pop -> empty=1.
REQ-037 SHALL be verified by running 20 simultaneous write/read cycles at count=3 -> count stays 3, pointers wrap at least twice, and the read sequence matches the write sequence.
REQ-038 SHALL be verified with rst=1 asserted at count=4 together with wrena=1 -> next cycle count=0, empty=1, overflow=0, and the write ignored.
